panel_serial_out: RTL and testbench

- Drives the front-panel display shift-register chain: four lanes, each two cascaded 74LV595 (16 bits per lane), sharing one SRCLK and one RCLK.
- Snapshots the parallel panel values (op code, STRT, SEL, register C) and serialises them MSB-first.
- After 16 shifts it pulses RCLK so all 64 display bits update together.
- Sits inside hardware_top, directly upstream of the 595 chips.

---
 rtl/panel_serial_pkg.sv | 38 +++
 rtl/serial_tick_gen.sv | 36 +++
 rtl/panel_serial_out.sv | 187 ++++++++++++++++++
 tb/tb_panel_serial_out.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_serial_pkg.sv
// Shared definitions for the front-panel 595 serialiser.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package panel_serial_pkg;

    localparam int LANE_W   = 16;
    localparam int LANE_CNT = 4;
    localparam int SNAP_W   = 61;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH_LO,
        LATCH_HI
    } state_t;

    typedef logic [LANE_CNT-1:0][LANE_W-1:0] lanes_t;

    // Field order matches the flat {op, strt, sel, reg_c} concatenation.
    typedef struct packed {
        logic [5:0]  op_code;
        logic [11:0] strt;
        logic [11:0] sel;
        logic [30:0] reg_c;
    } snap_t;

    // Panel fields -> the 16-bit word shifted out on each lane.
    function automatic lanes_t build_lanes(input snap_t s);
        lanes_t l;
        l[0] = s.reg_c[15:0];
        l[1] = {1'b0, s.reg_c[30:16]};
        l[2] = {s.strt[3:0], s.sel};
        l[3] = {2'b00, s.op_code, s.strt[11:4]};
        return l;
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Phase timer: strobes o_phase_end on the last clk cycle of each CLK_DIV-long FSM phase.
// Latency: o_phase_end is combinational from the counter; first strobe CLK_DIV cycles after a phase begins.
// Backpressure: none; the counter restarts whenever the FSM changes state or is idle.
//
// Ports:
//   clk, resetn   system clock, async active-low reset
//   i_run         FSM is in an active (non-idle) state
//   i_restart     FSM changes state at the next edge
//   o_phase_end   current phase ends this cycle
module serial_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_run,
    input  logic i_restart,
    output logic o_phase_end
);

    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_phase_end = i_run && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 8'd0;
        end else if (i_restart || !i_run || o_phase_end) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/panel_serial_out.sv
// Serialises a snapshot of the panel values into four 16-bit 595 lanes, then pulses RCLK.
// Latency: 1 + 34*CLK_DIV clk cycles from start decision to frame_done.
// Backpressure: update_req while busy is held in a single pending flag (requests collapse).
//
// Optional feature macro: PANEL_SERIAL_CHANGE_ONLY_EN (refresh expiry only sends a frame
// when the inputs differ from the last shipped snapshot).
//
// Ports:
//   clk, resetn              system clock, async active-low reset
//   pnl_op_code/strt/sel/reg_c_value   parallel display values (snapshotted per frame)
//   update_req               one-cycle request for a frame
//   serial_out_srclk/rclk    shift and storage clocks to all 595s
//   serial_out_ser_0..3      per-lane serial data
//   busy                     frame in progress
//   frame_done               one-cycle pulse at frame completion
module panel_serial_out
    import panel_serial_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_PERIOD = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  pnl_op_code,
    input  logic [11:0] pnl_strt_value,
    input  logic [11:0] pnl_sel_value,
    input  logic [30:0] pnl_reg_c_value,
    input  logic        update_req,
    output logic        serial_out_srclk,
    output logic        serial_out_rclk,
    output logic        serial_out_ser_0,
    output logic        serial_out_ser_1,
    output logic        serial_out_ser_2,
    output logic        serial_out_ser_3,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] REFRESH_RELOAD = 16'(REFRESH_PERIOD);

    state_t      r_state, w_state_nxt;
    lanes_t      r_lane, w_lane_nxt;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [15:0] r_refresh, w_refresh_nxt;
    logic        r_pending, w_pending_nxt;
    logic        w_frame_end;
    logic        w_phase_end;
    logic        w_expired;
    logic        w_auto;
    logic        w_go;
    snap_t       w_snap;

    logic        r_srclk, r_rclk, r_busy, r_frame_done;
    logic [3:0]  r_ser;

    assign w_snap    = {pnl_op_code, pnl_strt_value, pnl_sel_value, pnl_reg_c_value};
    assign w_expired = (r_refresh == 16'd0);

`ifdef PANEL_SERIAL_CHANGE_ONLY_EN
    logic [SNAP_W-1:0] r_last;
    logic              r_sent_any;

    // An expired timer only matters when the display would actually change.
    assign w_auto = w_expired && (!r_sent_any || (w_snap != r_last));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last     <= '0;
            r_sent_any <= 1'b0;
        end else if (r_state == IDLE && w_go) begin
            r_last     <= w_snap;
            r_sent_any <= 1'b1;
        end
    end
`else
    assign w_auto = w_expired;
`endif

    assign w_go = w_auto || update_req || r_pending;

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .resetn      (resetn),
        .i_run       (r_state != IDLE),
        .i_restart   (w_state_nxt != r_state),
        .o_phase_end (w_phase_end)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_lane_nxt    = r_lane;
        w_bit_cnt_nxt = r_bit_cnt;
        w_refresh_nxt = r_refresh;
        w_pending_nxt = r_pending;
        w_frame_end   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt   = LOW;
                    w_lane_nxt    = build_lanes(w_snap);
                    w_bit_cnt_nxt = 5'd0;
                    w_pending_nxt = 1'b0;
                end else if (w_expired) begin
                    // Only reachable when an unchanged display suppresses the frame.
                    w_refresh_nxt = REFRESH_RELOAD;
                end else begin
                    w_refresh_nxt = r_refresh - 16'd1;
                end
            end
            LOW: begin
                if (w_phase_end) w_state_nxt = HIGH;
            end
            HIGH: begin
                if (w_phase_end) begin
                    for (int i = 0; i < LANE_CNT; i++) begin
                        w_lane_nxt[i] = {r_lane[i][LANE_W-2:0], 1'b0};
                    end
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    w_state_nxt   = (r_bit_cnt == 5'd15) ? LATCH_LO : LOW;
                end
            end
            LATCH_LO: begin
                if (w_phase_end) w_state_nxt = LATCH_HI;
            end
            LATCH_HI: begin
                if (w_phase_end) begin
                    w_state_nxt   = IDLE;
                    w_frame_end   = 1'b1;
                    w_refresh_nxt = REFRESH_RELOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (update_req && r_state != IDLE) w_pending_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_lane    <= '0;
            r_bit_cnt <= 5'd0;
            r_refresh <= 16'd0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lane    <= w_lane_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_refresh <= w_refresh_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Outputs are registered from the next state so the 595 clocks never glitch;
    // ser only moves on entry to LOW or on leaving the shift phases, both with srclk low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_srclk      <= 1'b0;
            r_rclk       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ser        <= 4'd0;
        end else begin
            r_srclk      <= (w_state_nxt == HIGH);
            r_rclk       <= (w_state_nxt == LATCH_HI);
            r_busy       <= (w_state_nxt != IDLE);
            r_frame_done <= w_frame_end;
            for (int i = 0; i < LANE_CNT; i++) begin
                r_ser[i] <= (w_state_nxt == LOW || w_state_nxt == HIGH) ?
                            w_lane_nxt[i][LANE_W-1] : 1'b0;
            end
        end
    end

    assign serial_out_srclk = r_srclk;
    assign serial_out_rclk  = r_rclk;
    assign serial_out_ser_0 = r_ser[0];
    assign serial_out_ser_1 = r_ser[1];
    assign serial_out_ser_2 = r_ser[2];
    assign serial_out_ser_3 = r_ser[3];
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_panel_serial_out.sv
// Bench for panel_serial_out: models the 595 chain per lane and checks frame timing,
// pending-request collapsing, snapshot isolation, mid-frame reset and (optionally)
// change-only refresh.
module tb_panel_serial_out;

`ifdef PANEL_SERIAL_CHANGE_ONLY_EN
    localparam int RP = 16;
`else
    localparam int RP = 4096;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  op = '0;
    logic [11:0] strt = '0;
    logic [11:0] sel = '0;
    logic [30:0] regc = '0;
    logic        update_req = 1'b0;
    logic        srclk, rclk, ser_0, ser_1, ser_2, ser_3, busy, frame_done;

    panel_serial_out #(.CLK_DIV(2), .REFRESH_PERIOD(RP)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .pnl_op_code      (op),
        .pnl_strt_value   (strt),
        .pnl_sel_value    (sel),
        .pnl_reg_c_value  (regc),
        .update_req       (update_req),
        .serial_out_srclk (srclk),
        .serial_out_rclk  (rclk),
        .serial_out_ser_0 (ser_0),
        .serial_out_ser_1 (ser_1),
        .serial_out_ser_2 (ser_2),
        .serial_out_ser_3 (ser_3),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 595 chain model, sampled on the falling clk edge.
    wire [3:0]   w_ser = {ser_3, ser_2, ser_1, ser_0};
    logic [15:0] m_sr[4];
    logic [15:0] m_latch[4];
    int          m_shift_since = 0, m_last_shifts = 0, m_rclk_cnt = 0, m_done_cnt = 0;
    int          m_overlap = 0, m_ser_bad = 0;
    logic        p_srclk = 1'b0, p_rclk = 1'b0;
    logic [3:0]  p_ser = 4'd0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_sr[i]    = 16'h0;
            m_latch[i] = 16'h0;
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            m_shift_since = 0;
            p_srclk = 1'b0;
            p_rclk  = 1'b0;
            p_ser   = 4'd0;
        end else begin
            if (srclk && !p_srclk) begin
                for (int i = 0; i < 4; i++) m_sr[i] = {m_sr[i][14:0], w_ser[i]};
                m_shift_since++;
            end
            if (rclk && !p_rclk) begin
                for (int i = 0; i < 4; i++) m_latch[i] = m_sr[i];
                m_last_shifts = m_shift_since;
                m_shift_since = 0;
                m_rclk_cnt++;
            end
            if (srclk && rclk) m_overlap++;
            if (srclk && (w_ser != p_ser)) m_ser_bad++;
            if (frame_done) m_done_cnt++;
            p_srclk = srclk;
            p_rclk  = rclk;
            p_ser   = w_ser;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] o, input logic [11:0] st,
                          input logic [11:0] se, input logic [30:0] rc);
        op = o; strt = st; sel = se; regc = rc;
    endtask

    task automatic pulse_req();
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (frame_done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic [15:0] exp_l[4];
        exp_l = '{16'hAAAA, 16'h5555, 16'hC123, 16'h2AAB};
        set_in(6'h2A, 12'hABC, 12'h123, 31'h5555_AAAA);
        resetn = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({srclk, rclk, w_ser, busy, frame_done} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0", {srclk, rclk, w_ser, busy, frame_done});
        end
        resetn = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_start: busy=%b, want 1", busy);
        end
        wait_done(200, n);
        n_tests++;
        if (n + 1 !== 69) begin
            n_fail++;
            $display("FAIL reset_frame_len: got %0d cycles, want 69", n + 1);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_latch[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL reset_lane%0d: got %h, want %h", i, m_latch[i], exp_l[i]);
            end
        end
        n_tests++;
        if (m_last_shifts !== 16 || m_rclk_cnt !== 1) begin
            n_fail++;
            $display("FAIL reset_shift_count: shifts=%0d rclk=%0d, want 16 and 1",
                     m_last_shifts, m_rclk_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n, d0, r0;
        d0 = m_done_cnt;
        r0 = m_rclk_cnt;
        pulse_req();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start: busy=%b, want 1", busy);
        end
        repeat (10) tick(); pulse_req();
        repeat (10) tick(); pulse_req();
        repeat (10) tick(); pulse_req();
        wait_done(100, n);
        n_tests++;
        if (n < 0) begin
            n_fail++;
            $display("FAIL b2b_first_done: timed out, want frame_done");
        end
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_followup_start: busy=%b, want 1 on cycle after frame_done", busy);
        end
        wait_done(100, n);
        n_tests++;
        if (n + 1 !== 69) begin
            n_fail++;
            $display("FAIL b2b_followup_len: got %0d, want 69", n + 1);
        end
        repeat (150) tick();
        n_tests++;
        if (m_done_cnt - d0 !== 2 || m_rclk_cnt - r0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_frame_count: done=%0d rclk=%0d, want 2 and 2",
                     m_done_cnt - d0, m_rclk_cnt - r0);
        end
    endtask

    task automatic test_input_change();
        int n;
        logic [15:0] old_l[4];
        logic [15:0] new_l[4];
        old_l = '{16'hAAAA, 16'h5555, 16'hC123, 16'h2AAB};
        new_l = '{16'h5678, 16'h1234, 16'h0FFF, 16'h3F0F};
        pulse_req();
        repeat (20) tick();
        set_in(6'h3F, 12'h0F0, 12'hFFF, 31'h1234_5678);
        wait_done(100, n);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_latch[i] !== old_l[i]) begin
                n_fail++;
                $display("FAIL chg_old_lane%0d: got %h, want %h", i, m_latch[i], old_l[i]);
            end
        end
        // Request in the same cycle frame_done is high.
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_req_on_done: busy=%b, want 1", busy);
        end
        wait_done(100, n);
        n_tests++;
        if (n + 1 !== 69) begin
            n_fail++;
            $display("FAIL chg_frame_len: got %0d, want 69", n + 1);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_latch[i] !== new_l[i]) begin
                n_fail++;
                $display("FAIL chg_new_lane%0d: got %h, want %h", i, m_latch[i], new_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        logic [15:0] exp_l[4];
        exp_l = '{16'h0001, 16'h0000, 16'h0000, 16'h0180};
        pulse_req();
        for (int k = 0; k < 100 && m_shift_since != 7; k++) tick();
        n_tests++;
        if (m_shift_since !== 7) begin
            n_fail++;
            $display("FAIL mid_reach_bit7: shifts=%0d, want 7", m_shift_since);
        end
        set_in(6'h01, 12'h800, 12'h000, 31'h0000_0001);
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({srclk, rclk, w_ser, busy, frame_done} !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b, want 0", {srclk, rclk, w_ser, busy, frame_done});
        end
        n_tests++;
        if (m_latch[0] !== 16'h5678) begin
            n_fail++;
            $display("FAIL mid_latch_kept: got %h, want 5678", m_latch[0]);
        end
        repeat (3) tick();
        resetn = 1'b1;
        wait_done(200, n);
        n_tests++;
        if (n !== 69) begin
            n_fail++;
            $display("FAIL mid_frame_len: got %0d, want 69", n);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_latch[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL mid_lane%0d: got %h, want %h", i, m_latch[i], exp_l[i]);
            end
        end
        n_tests++;
        if (m_last_shifts !== 16) begin
            n_fail++;
            $display("FAIL mid_shift_count: got %0d, want 16", m_last_shifts);
        end
    endtask

`ifdef PANEL_SERIAL_CHANGE_ONLY_EN
    task automatic test_change_only();
        int n, d0;
        d0 = m_done_cnt;
        repeat (200) tick();
        n_tests++;
        if (m_done_cnt !== d0) begin
            n_fail++;
            $display("FAIL co_idle_frames: got %0d, want 0", m_done_cnt - d0);
        end
        set_in(6'h01, 12'h800, 12'h001, 31'h0000_0001);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy === 1'b1) begin
                n = k;
                break;
            end
        end
        n_tests++;
        if (n < 1 || n > 17) begin
            n_fail++;
            $display("FAIL co_start_delay: got %0d cycles, want 1..17", n);
        end
        wait_done(100, n);
        n_tests++;
        if (m_latch[2] !== 16'h0001) begin
            n_fail++;
            $display("FAIL co_lane2: got %h, want 0001", m_latch[2]);
        end
        d0 = m_done_cnt;
        repeat (100) tick();
        n_tests++;
        if (m_done_cnt !== d0) begin
            n_fail++;
            $display("FAIL co_after_frames: got %0d, want 0", m_done_cnt - d0);
        end
    endtask
`endif

    task automatic test_protocol();
        n_tests++;
        if (m_overlap !== 0) begin
            n_fail++;
            $display("FAIL proto_overlap: got %0d cycles, want 0", m_overlap);
        end
        n_tests++;
        if (m_ser_bad !== 0) begin
            n_fail++;
            $display("FAIL proto_ser_stable: got %0d changes, want 0", m_ser_bad);
        end
        n_tests++;
        if (m_rclk_cnt !== m_done_cnt) begin
            n_fail++;
            $display("FAIL proto_rclk_per_frame: rclk=%0d, want %0d", m_rclk_cnt, m_done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
`ifdef PANEL_SERIAL_CHANGE_ONLY_EN
        test_change_only();
`endif
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
